axi_rr_arbiter: RTL
===================

Name: axi_rr_arbiter

Overview:
- Sequencing arbiter for the 6-way AXI interconnect channel mux.
- Shares one slave-side channel among six masters using round-robin priority.
- Holds each grant until the granted transaction completes.
- Drives the mux select: 3'b000..3'b101 selects a master, 3'b110 forces the error pattern (all ones), 3'b111 idles the channel (all zeros).
- Includes a watchdog that evicts a master that stalls its transaction.

Parameters:
- TIMEOUT, 256: cycles a grant may last without done before eviction; legal range 2..65535.
- ERR_HOLD, 2: cycles the error pattern is driven after eviction; legal range 1..255.
- CNT_W, 16: watchdog counter width; must satisfy 2^CNT_W > max(TIMEOUT, ERR_HOLD).

Ports:
- clk  in  1  Sole clock; all state updates on the rising edge.
- rst  in  1  Synchronous, active-high reset.
- req  in  6  Per-master request; bit i = master i has a pending transaction.
- done  in  1  Granted transaction complete (last-beat handshake on the slave side); sampled only in GRANT.
- sel  out  3  Mux select: 0..5 = granted master, 3'b110 = error, 3'b111 = idle.
- grant  out  6  One-hot grant, consistent with sel; all zero in IDLE and ERR.
- busy  out  1  High in GRANT and ERR.
- timeout  out  1  Single-cycle pulse on the cycle GRANT -> ERR is taken.

Behaviour:
- All outputs are registered.
- Reset values: state = IDLE, sel = 3'b111, grant = 0, busy = 0, timeout = 0, last_ptr = 5 (master 0 has highest priority first), counter = 0.
- States:
  - IDLE: sel = 111.
    - If req != 0, the winner is the first set bit searching last_ptr+1, last_ptr+2, ... mod 6.
    - Next cycle: GRANT, sel = winner, grant bit set, last_ptr = winner, counter = 0.
    - If req == 0, stay in IDLE.
  - GRANT:
    - done = 1 -> IDLE next cycle.
    - Else if counter == TIMEOUT-1 -> ERR next cycle: sel = 110, timeout pulses for 1 cycle, counter = 0.
    - Else counter increments.
  - ERR: counter increments; when counter == ERR_HOLD-1 -> IDLE.
- Latency:
  - req to grant: 1 cycle from the edge at which IDLE samples req.
  - done to release: 1 cycle.
  - There is always at least 1 IDLE cycle between grants, including back-to-back requests from the same master.
- The grant is sticky: deasserting req while in GRANT does not release the grant. Only done or timeout releases it.
- done and the timeout condition in the same cycle: done wins; no ERR, no timeout pulse.
- done while in IDLE or ERR: ignored.
- Pointer wrap: when last_ptr = 5, the search order is 0, 1, 2, 3, 4, 5.
- An evicted master still updates last_ptr, so it gets lowest priority in the next arbitration.
- Reset asserted mid-GRANT or mid-ERR: the next cycle shows the reset values. No timeout pulse is generated by the reset.
- Invariant: sel is never 3'b110 outside ERR and never 3'b111 outside IDLE. grant == (1 << sel) exactly when in GRANT.

Decomposition:
- Shared package axi_ic_pkg holds:
  - constants SEL_IDLE = 3'b111, SEL_ERR = 3'b110, N_MASTERS = 6;
  - the state enum IDLE/GRANT/ERR.
- The mux and this arbiter both import the select codes from axi_ic_pkg.
- One sub-module, rr_pick: a combinational 6-bit round-robin priority encoder.
  - Inputs: req, last_ptr.
  - Outputs: winner index and valid.
  - Unit-testable on its own.
- The FSM and watchdog counter live in the top module.

Test Plan:
- Reset, then req = 6'b000001 from cycle 2 -> sel = 000, grant = 000001 one cycle later; done pulse -> sel = 111 on the next cycle.
- req = 6'b111111 held, done pulsed 2 cycles after each grant -> grant order 0, 1, 2, 3, 4, 5, 0, with one idle cycle (sel = 111) between grants.
- last_ptr = 3, req = 6'b001001 -> master 0 wins (wrap past 5); the following arbitration with the same req picks master 3.
- TIMEOUT = 4, grant master 2 with no done -> exactly 4 GRANT cycles, then timeout = 1 for 1 cycle, sel = 110 for ERR_HOLD = 2 cycles, then sel = 111.
- done asserted on the cycle counter == TIMEOUT-1 -> IDLE next, timeout stays 0; req dropped mid-grant -> grant held until done.
- rst asserted during ERR -> next cycle sel = 111, grant = 0, busy = 0; first grant after reset goes to master 0 when req = 6'b100001.

Source files
------------

// File: rtl/axi_ic_pkg.sv
// Shared definitions for the 6-way AXI interconnect channel mux and its arbiter.
// The mux decodes the same select codes the arbiter drives.
package axi_ic_pkg;

  localparam int N_MASTERS = 6;
  localparam int SEL_W     = 3;

  localparam logic [SEL_W-1:0] SEL_IDLE = 3'b111;
  localparam logic [SEL_W-1:0] SEL_ERR  = 3'b110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ERR   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/axi_rr_arbiter_rr_pick.sv
// Combinational round-robin priority encoder over six requesters.
// The search starts just after last_ptr and wraps modulo six.
module rr_pick
  import axi_ic_pkg::*;
(
  input  logic [N_MASTERS-1:0] req_i,
  input  logic [SEL_W-1:0]     last_ptr_i,
  output logic [SEL_W-1:0]     winner_o,
  output logic                 valid_o
);

  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      int idx;
      idx = (int'(last_ptr_i) + k) % N_MASTERS;
      if (!valid_o && req_i[idx]) begin
        valid_o  = 1'b1;
        winner_o = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/axi_rr_arbiter.sv
// Round-robin arbiter for the shared slave-side AXI channel: sticky grants,
// watchdog eviction into a short error-pattern phase, all outputs registered.
module axi_rr_arbiter
  import axi_ic_pkg::*;
#(
  parameter int TIMEOUT  = 256,
  parameter int ERR_HOLD = 2,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] req,
  input  logic                 done,
  output logic [SEL_W-1:0]     sel,
  output logic [N_MASTERS-1:0] grant,
  output logic                 busy,
  output logic                 timeout
);

  localparam logic [CNT_W-1:0] GRANT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ERR_LAST   = CNT_W'(ERR_HOLD - 1);
  localparam logic [SEL_W-1:0] PTR_RESET  = SEL_W'(N_MASTERS - 1);

  arb_state_e             state_q, state_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [N_MASTERS-1:0]   grant_q, grant_d;
  logic                   busy_q, busy_d;
  logic                   timeout_q, timeout_d;
  logic [SEL_W-1:0]       last_ptr_q, last_ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [SEL_W-1:0]       pick_winner;
  logic                   pick_valid;

  rr_pick u_rr_pick (
    .req_i      (req),
    .last_ptr_i (last_ptr_q),
    .winner_o   (pick_winner),
    .valid_o    (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= SEL_IDLE;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      last_ptr_q <= PTR_RESET;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      last_ptr_q <= last_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    grant_d    = grant_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    last_ptr_d = last_ptr_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d    = GRANT;
          sel_d      = pick_winner;
          grant_d    = N_MASTERS'(1) << pick_winner;
          busy_d     = 1'b1;
          last_ptr_d = pick_winner;
          cnt_d      = '0;
        end
      end
      GRANT: begin
        // done takes precedence over an expiring watchdog in the same cycle
        if (done) begin
          state_d = IDLE;
          sel_d   = SEL_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == GRANT_LAST) begin
          state_d   = ERR;
          sel_d     = SEL_ERR;
          grant_d   = '0;
          timeout_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ERR: begin
        if (cnt_q == ERR_LAST) begin
          state_d = IDLE;
          sel_d   = SEL_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = SEL_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  assign sel     = sel_q;
  assign grant   = grant_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule
